// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and sizes for the segment-display arbiter.
package seg_display_arbiter_pkg;
  localparam int N_REQ  = 4;
  localparam int W_IDX  = 2;
  localparam int W_WORD = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or above ptr (mod N_REQ) not in excl.
module seg_rr_pick
  import seg_display_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [W_IDX-1:0] ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [N_REQ-1:0] win_oh,
  output logic [W_IDX-1:0] win_idx,
  output logic             win_any
);

  logic [N_REQ-1:0] cand;
  logic [W_IDX-1:0] idx;

  always_comb begin
    cand    = req & ~excl;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + W_IDX'(i);
      if (!win_any && cand[idx]) begin
        win_any     = 1'b1;
        win_idx     = idx;
        win_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbiter for a 4-digit multiplexed segment display.
// Optional macro SEG_ARB_PREEMPT_EN: requester 0 wins arbitration and preempts other owners.
//
// state | meaning
// IDLE  | no owner, gnt all-zero, display blanked one cycle later
// OWN   | owner_q holds the display; hold_q counts cycles since grant (saturating)
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int MIN_HOLD = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*W_WORD-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [W_IDX-1:0]        owner,
  output logic [W_WORD-1:0]       disp_data,
  output logic                    disp_valid
);

  localparam logic [15:0] HOLD_MAX = 16'(MIN_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [W_IDX-1:0] owner_q, owner_d;
  logic [W_IDX-1:0] rr_q, rr_d;
  logic [15:0]      hold_q, hold_d;

  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] excl;
  logic [N_REQ-1:0] pick_oh;
  logic [W_IDX-1:0] pick_idx;
  logic             pick_any;
  logic [W_IDX-1:0] win_idx;

  assign owner_oh = N_REQ'(1) << owner_q;
  assign excl     = (state_q == OWN) ? owner_oh : '0;

  seg_rr_pick u_pick (
    .req     (req),
    .ptr     (rr_q),
    .excl    (excl),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_any (pick_any)
  );

`ifdef SEG_ARB_PREEMPT_EN
  assign win_idx = (req[0] && !excl[0]) ? '0 : pick_idx;
`else
  assign win_idx = pick_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OWN;
          owner_d = win_idx;
          rr_d    = win_idx + W_IDX'(1);
          hold_d  = '0;
        end
      end
      OWN: begin
        // Release wins over everything else: the driver always sees a blank gap.
        if (!req[owner_q]) begin
          state_d = IDLE;
`ifdef SEG_ARB_PREEMPT_EN
        end else if (owner_q != '0 && req[0]) begin
          owner_d = '0;
          rr_d    = W_IDX'(1);
          hold_d  = '0;
`endif
        end else if (hold_q == HOLD_MAX && pick_any) begin
          owner_d = win_idx;
          rr_d    = win_idx + W_IDX'(1);
          hold_d  = '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt   = (state_q == OWN) ? owner_oh : '0;
    owner = owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else if (|gnt) begin
      disp_data  <= req_data[{owner_q, 4'b0000} +: W_WORD];
      disp_valid <= 1'b1;
    end else begin
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_seg_display_arbiter;
  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [15:0] disp_data;
  logic        disp_valid;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_own;
  int          m_owner, m_rr, m_hold;
  logic [15:0] m_dd;
  bit          m_dv;

  seg_display_arbiter #(.MIN_HOLD(MH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .owner      (owner),
    .disp_data  (disp_data),
    .disp_valid (disp_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int rr, input int excl);
`ifdef SEG_ARB_PREEMPT_EN
    if (r[0] && excl != 0) return 0;
`endif
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (rr + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic grant(input int w);
    m_own   = 1'b1;
    m_owner = w;
    m_rr    = (w + 1) % 4;
    m_hold  = 0;
  endtask

  task automatic step_model();
    int w;
    if (rst) begin
      m_own = 1'b0; m_owner = 0; m_rr = 0; m_hold = 0; m_dd = '0; m_dv = 1'b0;
    end else begin
      m_dv = m_own;
      m_dd = m_own ? req_data[m_owner*16 +: 16] : 16'h0000;
      if (!m_own) begin
        w = pick(req, m_rr, -1);
        if (w >= 0) grant(w);
      end else if (!req[m_owner]) begin
        m_own = 1'b0;
`ifdef SEG_ARB_PREEMPT_EN
      end else if (m_owner != 0 && req[0]) begin
        grant(0);
`endif
      end else begin
        w = pick(req, m_rr, m_owner);
        if (m_hold == MH - 1 && w >= 0) grant(w);
        else if (m_hold < MH - 1) m_hold++;
      end
    end
  endtask

  // One clock: model advances with the DUT edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    step_model();
    @(negedge clk);
    chk("gnt", {28'd0, gnt}, m_own ? (32'd1 << m_owner) : 32'd0);
    if (m_own) chk("owner", {30'd0, owner}, m_owner);
    chk("disp_valid", {31'd0, disp_valid}, {31'd0, m_dv});
    chk("disp_data", {16'd0, disp_data}, {16'd0, m_dd});
  endtask

  initial begin
    int cyc;
    rst = 1'b1; req = '0; req_data = '0;
    m_own = 1'b0; m_owner = 0; m_rr = 0; m_hold = 0; m_dd = '0; m_dv = 1'b0;
    tick(); tick();
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_valid", {31'd0, disp_valid}, 32'd0);

    rst = 1'b0; req = 4'b0100; req_data[47:32] = 16'h1234;
    tick();
    chk("r026_gnt", {28'd0, gnt}, 32'h4);
    chk("r026_owner", {30'd0, owner}, 32'd2);
    tick();
    chk("r026_data", {16'd0, disp_data}, 32'h1234);
    chk("r026_valid", {31'd0, disp_valid}, 32'd1);

    req = 4'b0101;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cyc++;
      chk("r027_nogap", {31'd0, (gnt != 4'b0000)}, 32'd1);
      if (gnt == 4'b0001) break;
    end
    chk("r027_gnt", {28'd0, gnt}, 32'h1);
`ifdef SEG_ARB_PREEMPT_EN
    chk("r027_cycles", cyc, 32'd1);
`else
    chk("r027_cycles", cyc, 32'd3);
`endif

    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0010; tick();
    chk("r028_own1", {28'd0, gnt}, 32'h2);
    req = 4'b1000; tick();
    chk("r028_gap", {28'd0, gnt}, 32'h0);
    tick();
    chk("r028_gnt3", {28'd0, gnt}, 32'h8);
    chk("r028_blank", {31'd0, disp_valid}, 32'd0);
    tick();
    chk("r028_valid", {31'd0, disp_valid}, 32'd1);

    rst = 1'b1; tick();
    chk("r029_gnt", {28'd0, gnt}, 32'h0);
    chk("r029_owner", {30'd0, owner}, 32'd0);
    chk("r029_data", {16'd0, disp_data}, 32'h0);
    chk("r029_valid", {31'd0, disp_valid}, 32'd0);
    rst = 1'b0; req = 4'b1111; tick();
    chk("r029_regrant", {28'd0, gnt}, 32'h1);

    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b1000; tick(); tick();
    req = 4'b1001; tick();
`ifdef SEG_ARB_PREEMPT_EN
    chk("r030_gnt", {28'd0, gnt}, 32'h1);
`else
    chk("r030_gnt", {28'd0, gnt}, 32'h8);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99) == 0);
      if ($urandom_range(3) == 0) req = 4'($urandom);
      req_data = {$urandom, $urandom};
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
